// File: rtl/ysyx_22040228_div_ctrl.sv
// Sequencing controller between EX and the multi-cycle radix-2 divider.
// Prepares operands (W-variant extension), resolves divide-by-zero and
// signed overflow locally, runs the divider handshake, stalls EX, and
// drains an in-flight divide on flush.
`timescale 1ns/1ps

`ifndef INST_DIV
  `define INST_DIV   8'h40
`endif
`ifndef INST_DIVU
  `define INST_DIVU  8'h41
`endif
`ifndef INST_DIVW
  `define INST_DIVW  8'h42
`endif
`ifndef INST_DIVUW
  `define INST_DIVUW 8'h43
`endif
`ifndef INST_REM
  `define INST_REM   8'h44
`endif
`ifndef INST_REMU
  `define INST_REMU  8'h45
`endif
`ifndef INST_REMW
  `define INST_REMW  8'h46
`endif
`ifndef INST_REMUW
  `define INST_REMUW 8'h47
`endif

module ysyx_22040228_div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [7:0]  ex_opcode,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  input  logic        flush,
  output logic        ex_stall,
  output logic        res_valid,
  output logic [63:0] res_data,
  output logic        busy,
  output logic        div_ready,
  output logic [63:0] div_dividend,
  output logic [63:0] div_diviser,
  output logic [7:0]  div_opcode,
  input  logic [63:0] div_rem_data,
  input  logic        div_finish
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_e;

  localparam logic [63:0] D_MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] W_MIN = 64'hFFFF_FFFF_8000_0000;

  state_e      state_q;
  logic [63:0] res_q, dvd_q, dvs_q;
  logic [7:0]  opc_q;
  logic        w_q;

  logic        is_div, is_w, is_sgn, is_rem;
  logic [63:0] dvd_p, dvs_p, spec_res;
  logic        div_zero, ovf, special, accept;

  // W results keep the low word and sign-extend it
  function automatic logic [63:0] wext(input logic w, input logic [63:0] r);
    return w ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  // opcode decode
  always_comb begin
    is_div = 1'b0;
    is_w   = 1'b0;
    is_sgn = 1'b0;
    is_rem = 1'b0;
    case (ex_opcode)
      `INST_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
      `INST_DIVU:  begin is_div = 1'b1; end
      `INST_DIVW:  begin is_div = 1'b1; is_sgn = 1'b1; is_w = 1'b1; end
      `INST_DIVUW: begin is_div = 1'b1; is_w = 1'b1; end
      `INST_REM:   begin is_div = 1'b1; is_sgn = 1'b1; is_rem = 1'b1; end
      `INST_REMU:  begin is_div = 1'b1; is_rem = 1'b1; end
      `INST_REMW:  begin is_div = 1'b1; is_sgn = 1'b1; is_rem = 1'b1; is_w = 1'b1; end
      `INST_REMUW: begin is_div = 1'b1; is_rem = 1'b1; is_w = 1'b1; end
      default: ;
    endcase
  end

  // operand prep and special-case resolution on the prepared operands
  always_comb begin
    dvd_p = rs1_data;
    dvs_p = rs2_data;
    if (is_w) begin
      dvd_p = is_sgn ? {{32{rs1_data[31]}}, rs1_data[31:0]} : {32'b0, rs1_data[31:0]};
      dvs_p = is_sgn ? {{32{rs2_data[31]}}, rs2_data[31:0]} : {32'b0, rs2_data[31:0]};
    end
    div_zero = (dvs_p == 64'b0);
    ovf      = is_sgn && (dvd_p == (is_w ? W_MIN : D_MIN)) && (&dvs_p);
    special  = div_zero | ovf;
    if (is_rem) spec_res = div_zero ? dvd_p : 64'b0;
    else        spec_res = div_zero ? '1 : dvd_p;
  end

  assign accept = (state_q == IDLE) && ex_valid && is_div && !flush;

  // control FSM; operand regs stay put until the op leaves the divider
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      opc_q   <= '0;
      w_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          w_q <= is_w;
          if (special) begin
            res_q   <= wext(is_w, spec_res);
            state_q <= DONE;
          end else begin
            dvd_q   <= dvd_p;
            dvs_q   <= dvs_p;
            opc_q   <= ex_opcode;
            state_q <= ISSUE;
          end
        end
        ISSUE: state_q <= flush ? DRAIN : WAIT;
        WAIT: begin
          if (flush) begin
            // a finish coinciding with flush closes the op; nothing to drain
            if (div_finish) begin
              state_q <= IDLE;
              dvd_q   <= '0;
              dvs_q   <= '0;
              opc_q   <= '0;
            end else begin
              state_q <= DRAIN;
            end
          end else if (div_finish) begin
            res_q   <= wext(w_q, div_rem_data);
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          dvd_q   <= '0;
          dvs_q   <= '0;
          opc_q   <= '0;
        end
        DRAIN: if (div_finish) begin
          state_q <= IDLE;
          dvd_q   <= '0;
          dvs_q   <= '0;
          opc_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign div_ready    = (state_q == ISSUE);
  assign res_valid    = (state_q == DONE) && !flush;
  assign res_data     = res_q;
  assign div_dividend = dvd_q;
  assign div_diviser  = dvs_q;
  assign div_opcode   = opc_q;
  assign ex_stall     = accept || (state_q == ISSUE) || (state_q == WAIT) ||
                        ((state_q == DRAIN) && ex_valid && is_div);

endmodule

// File: tb/tb_ysyx_22040228_div_ctrl.sv
// Directed bench for ysyx_22040228_div_ctrl with a behavioural divider that
// finishes 67 cycles after its start pulse.
`timescale 1ns/1ps

`ifndef INST_DIV
  `define INST_DIV   8'h40
`endif
`ifndef INST_DIVU
  `define INST_DIVU  8'h41
`endif
`ifndef INST_DIVW
  `define INST_DIVW  8'h42
`endif
`ifndef INST_DIVUW
  `define INST_DIVUW 8'h43
`endif
`ifndef INST_REM
  `define INST_REM   8'h44
`endif
`ifndef INST_REMU
  `define INST_REMU  8'h45
`endif
`ifndef INST_REMW
  `define INST_REMW  8'h46
`endif
`ifndef INST_REMUW
  `define INST_REMUW 8'h47
`endif

module tb_ysyx_22040228_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic [7:0]  ex_opcode = 8'h0;
  logic [63:0] rs1_data = '0, rs2_data = '0;
  logic        flush = 1'b0;
  logic        ex_stall, res_valid, busy, div_ready;
  logic [63:0] res_data, div_dividend, div_diviser;
  logic [7:0]  div_opcode;
  logic [63:0] div_rem_data;
  logic        div_finish;

  int errors = 0;
  int checks = 0;
  int reissue = 0;
  logic [6:0] cnt;

  ysyx_22040228_div_ctrl dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .ex_stall(ex_stall), .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .div_ready(div_ready), .div_dividend(div_dividend),
    .div_diviser(div_diviser), .div_opcode(div_opcode),
    .div_rem_data(div_rem_data), .div_finish(div_finish)
  );

  always #5 clk = ~clk;

  // behavioural divider: result computed from the held inputs at finish time
  function automatic logic [63:0] dmodel(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    r = 64'h0;
    if (b != 64'h0) begin
      case (op)
        `INST_DIV, `INST_DIVW:   r = $signed(a) / $signed(b);
        `INST_DIVU, `INST_DIVUW: r = a / b;
        `INST_REM, `INST_REMW:   r = $signed(a) % $signed(b);
        `INST_REMU, `INST_REMUW: r = a % b;
        default: r = 64'h0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) cnt <= 7'd0;
    else begin
      if (div_ready && cnt != 7'd0) reissue <= reissue + 1;
      if (div_ready)          cnt <= 7'd1;
      else if (cnt == 7'd67)  cnt <= 7'd0;
      else if (cnt != 7'd0)   cnt <= cnt + 7'd1;
    end
  end
  assign div_finish   = (cnt == 7'd67);
  assign div_rem_data = div_finish ? dmodel(div_opcode, div_dividend, div_diviser) : 64'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // drive one op in IDLE and follow it to DONE and back to IDLE
  task automatic run_op(input string tag, input logic [7:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input bit special);
    int n;
    bit stall_ok;
    int rdy;
    @(negedge clk);
    ex_valid = 1'b1; ex_opcode = op; rs1_data = a; rs2_data = b;
    #1 chk({tag, ":stall_acc"}, 64'(ex_stall), 64'd1);
    @(negedge clk);
    ex_valid = 1'b0; ex_opcode = 8'h0; rs1_data = '0; rs2_data = '0;
    #1;
    if (special) begin
      chk({tag, ":no_ready"}, 64'(div_ready), 64'd0);
      chk({tag, ":res_valid_t1"}, 64'(res_valid), 64'd1);
      chk({tag, ":res_data"}, res_data, exp);
      chk({tag, ":stall_done"}, 64'(ex_stall), 64'd0);
    end else begin
      chk({tag, ":ready_t1"}, 64'(div_ready), 64'd1);
      n = 1; stall_ok = 1'b1; rdy = 0;
      while (!res_valid && n < 200) begin
        if (!ex_stall) stall_ok = 1'b0;
        @(negedge clk); #1;
        n++;
        if (div_ready) rdy++;
      end
      chk({tag, ":latency"}, 64'(n), 64'd69);
      chk({tag, ":res_data"}, res_data, exp);
      chk({tag, ":stall_done"}, 64'(ex_stall), 64'd0);
      chk({tag, ":stall_hold"}, 64'(stall_ok), 64'd1);
      chk({tag, ":ready_once"}, 64'(rdy), 64'd0);
    end
    @(negedge clk); #1;
    chk({tag, ":res_valid_off"}, 64'(res_valid), 64'd0);
    chk({tag, ":res_hold"}, res_data, exp);
    chk({tag, ":idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    #2;
    chk("rst:ex_stall", 64'(ex_stall), 64'd0);
    chk("rst:res_valid", 64'(res_valid), 64'd0);
    chk("rst:res_data", res_data, 64'd0);
    chk("rst:busy", 64'(busy), 64'd0);
    chk("rst:div_ready", 64'(div_ready), 64'd0);
    chk("rst:dividend", div_dividend, 64'd0);
    chk("rst:diviser", div_diviser, 64'd0);
    chk("rst:opcode", 64'(div_opcode), 64'd0);
    @(negedge clk); rst = 1'b1;

    run_op("divu", `INST_DIVU, 64'd100, 64'd7, 64'd14, 1'b0);
    run_op("remu", `INST_REMU, 64'd100, 64'd7, 64'd2, 1'b0);
    run_op("div_neg", `INST_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op("rem_neg", `INST_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("divw_ovf", `INST_DIVW, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1'b1);
    run_op("remuw_z", `INST_REMUW, 64'd5, 64'd0, 64'd5, 1'b1);
    run_op("div_ovf", `INST_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1'b1);
    run_op("divu_z", `INST_DIVU, 64'd12345, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op("divw", `INST_DIVW, 64'hABCD_0000_FFFF_FFF0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
    run_op("divuw", `INST_DIVUW, 64'h1234_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

    // non-div opcode is ignored
    @(negedge clk);
    ex_valid = 1'b1; ex_opcode = 8'h13; rs1_data = 64'd1; rs2_data = 64'd1;
    #1 chk("nondiv:stall", 64'(ex_stall), 64'd0);
    @(negedge clk); #1 chk("nondiv:busy", 64'(busy), 64'd0);

    // flush in the accept cycle: nothing accepted
    ex_opcode = `INST_DIVU; flush = 1'b1;
    #1 chk("flush_acc:stall", 64'(ex_stall), 64'd0);
    @(negedge clk); ex_valid = 1'b0; flush = 1'b0;
    #1 chk("flush_acc:busy", 64'(busy), 64'd0);

    // flush in WAIT, then a new op waits out the drain
    @(negedge clk);
    ex_valid = 1'b1; ex_opcode = `INST_DIVU; rs1_data = 64'd100; rs2_data = 64'd7;
    @(negedge clk); ex_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1 chk("drain:no_valid_flush", 64'(res_valid), 64'd0);
    @(negedge clk); flush = 1'b0;
    ex_valid = 1'b1; ex_opcode = `INST_DIVU; rs1_data = 64'd9; rs2_data = 64'd3;
    #1;
    chk("drain:busy", 64'(busy), 64'd1);
    chk("drain:stall_new", 64'(ex_stall), 64'd1);
    n = 11;
    while (!res_valid && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    ex_valid = 1'b0;
    chk("drain:latency", 64'(n), 64'd138);
    chk("drain:res_data", res_data, 64'd3);
    @(negedge clk); #1 chk("drain:idle", 64'(busy), 64'd0);

    // reset in WAIT clears everything immediately
    @(negedge clk);
    ex_valid = 1'b1; ex_opcode = `INST_DIV; rs1_data = 64'hFFFF_FFFF_FFFF_FFF9; rs2_data = 64'd2;
    @(negedge clk); ex_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw:busy", 64'(busy), 64'd0);
    chk("rstw:stall", 64'(ex_stall), 64'd0);
    chk("rstw:res_data", res_data, 64'd0);
    chk("rstw:div_ready", 64'(div_ready), 64'd0);
    chk("rstw:dividend", div_dividend, 64'd0);
    chk("rstw:diviser", div_diviser, 64'd0);
    chk("rstw:opcode", 64'(div_opcode), 64'd0);
    @(negedge clk); rst = 1'b1;
    run_op("post_rst", `INST_REMU, 64'd100, 64'd7, 64'd2, 1'b0);

    chk("divider:reissue", 64'(reissue), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22040228_div_ctrl.md
# ysyx_22040228_div_ctrl

Sequencing controller between the EX stage and the 64-bit multi-cycle radix-2 divider. It accepts one RV64M divide/remainder op at a time and prepares operands, including 32-bit W-variant extension. It resolves divide-by-zero and signed overflow without starting the divider, issues the divider start pulse and holds its inputs stable for the whole iteration. It stalls EX until the result returns, applies W-result sign extension, and drains in-flight work on pipeline flush.

## Interface
- No parameters; opcode encodings are the `INST_DIV/DIVU/DIVW/DIVUW/REM/REMU/REMW/REMUW` macros from the shared defines file.
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- ex_valid  input  1  EX holds a valid instruction
- ex_opcode  input  8  EX instruction opcode
- rs1_data  input  64  dividend source
- rs2_data  input  64  divisor source
- flush  input  1  kill EX and any op in flight
- ex_stall  output  1  hold EX/upstream this cycle
- res_valid  output  1  one-cycle pulse, res_data valid
- res_data  output  64  quotient or remainder, final form
- busy  output  1  state != IDLE
- div_ready  output  1  divider start pulse
- div_dividend  output  64  to divider `dividend`
- div_diviser  output  64  to divider `diviser`
- div_opcode  output  8  to divider `inst_opcode`
- div_rem_data  input  64  divider result
- div_finish  input  1  divider completion pulse

## Operation
- is_div = ex_opcode is one of the eight div/rem macros. Accept when state==IDLE, ex_valid, is_div and !flush. On accept, register opcode and prepared operands.
- Operand prep: DIVW/REMW sign-extend [31:0] to 64 bits. DIVUW/REMUW zero-extend. Others pass through.
- Special cases, decided on prepared operands:
  - divisor==0: quotient = all ones, remainder = dividend.
  - signed op with dividend==most-negative and divisor==all ones (0x8000_0000_0000_0000/-1, or for W ops 0xFFFF_FFFF_8000_0000/-1): quotient = dividend, remainder = 0.
  - For a special case, go to DONE directly; the divider is never started.
- States:
  - IDLE
  - ISSUE: div_ready=1 for exactly one cycle, then go to WAIT.
  - WAIT: on div_finish, capture div_rem_data and go to DONE.
  - DONE: res_valid=1, then go to IDLE.
  - DRAIN: on div_finish, discard the result and go to IDLE.
- div_dividend, div_diviser and div_opcode are registered. They hold constant from ISSUE until the cycle after div_finish, because the divider decodes div_opcode combinationally at finish. They are zero in IDLE.
- Result: W ops produce {{32{r[31]}}, r[31:0]}; others produce r. res_data is registered and holds its last value outside res_valid.
- ex_stall (combinational):
  - 1 in the accept cycle and in ISSUE/WAIT.
  - 0 in DONE, so EX retires with res_data in that cycle.
  - In DRAIN: 1 only if ex_valid & is_div.
- Flush:
  - In ISSUE or WAIT: go to DRAIN, no res_valid.
  - In DONE: res_valid is suppressed and the state goes to IDLE.
  - In the accept cycle: nothing is accepted.
  - div_finish arriving in the same cycle as flush is discarded.
- Reset mid-operation: asynchronous return to IDLE with all outputs cleared. The divider instance is reset by the same reset network.
- Non-div opcodes are ignored. ex_stall=0 for them unless the controller is busy with a div op owned by EX.

## Timing
- Reset values: ex_stall=0, res_valid=0, res_data=0, busy=0, div_ready=0, div_dividend=0, div_diviser=0, div_opcode=0.
- Normal op accepted in cycle T:
  - div_ready=1 in T+1.
  - The current divider raises div_finish in T+68.
  - res_valid in T+69.
  - ex_stall=1 for T..T+68.
  - Total latency is always div_finish cycle + 1.
- Special case accepted in cycle T: res_valid in T+1 and ex_stall=1 only in T.
- Back-to-back ops: the next op can be accepted in the cycle after DONE, i.e. IDLE. EX presents it while ex_stall is low in DONE and holds it until accepted.
- div_ready is never reasserted before div_finish for the previous start.

## Test plan
- DIVU: rs1=100, rs2=7 → res_data=14 at the cycle after div_finish. REMU with the same operands → 2. ex_stall high throughout.
- DIV -7/2 → 0xFFFF_FFFF_FFFF_FFFD. REM -7/2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIVW rs1=0x0000_0001_8000_0000, rs2=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000 in T+1, div_ready never asserted. REMUW 5/0 → 5 in T+1.
- DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000 in T+1. DIVU x/0 → all ones.
- Flush in WAIT at T+10: no res_valid, state DRAIN. A new DIVU 9/3 presented during DRAIN stalls, is accepted after div_finish, and returns 3.
- Reset asserted during WAIT → all outputs 0 immediately. Next op after release completes correctly.
